// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types for the two-requester I2C bus arbiter: command word, burst
// counter type and arbiter state encoding.
package i2c_bus_arbiter_pkg;

  localparam int c_i2c_arb_num_req = 2;

  typedef logic [7:0] t_i2c_burst;

  typedef struct packed {
    logic       we;
    logic [6:0] addr_slave;
    logic [7:0] addr_reg;
    t_i2c_burst burst_num;
  } t_i2c_cmd;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DRAIN} t_i2c_arb_state;

endpackage

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter serializing whole I2C transactions from two requesters
// onto one master. Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int p_num_req        = c_i2c_arb_num_req,
  parameter int p_timeout_cycles = 2_500_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [p_num_req-1:0] i_req_cmd_valid,
  input  t_i2c_cmd             i_req_cmd_data [p_num_req],
  output logic [p_num_req-1:0] o_req_cmd_ready,
  input  logic [p_num_req-1:0] i_req_wr_valid,
  input  logic [7:0]           i_req_wr_data [p_num_req],
  output logic [p_num_req-1:0] o_req_wr_ready,
  output logic [p_num_req-1:0] o_req_rd_valid,
  output logic [7:0]           o_req_rd_data,
  input  logic [p_num_req-1:0] i_req_rd_ready,
  output logic                 o_m_cmd_valid,
  output t_i2c_cmd             o_m_cmd_data,
  input  logic                 i_m_cmd_ready,
  output logic                 o_m_wr_valid,
  output logic [7:0]           o_m_wr_data,
  input  logic                 i_m_wr_ready,
  input  logic                 i_m_rd_valid,
  input  logic [7:0]           i_m_rd_data,
  output logic                 o_m_rd_ready,
  input  logic                 i_m_busy,
  output logic [p_num_req-1:0] o_grant,
  output logic                 o_drop,
  output logic                 o_timeout
);

  if (p_num_req != c_i2c_arb_num_req || p_timeout_cycles < 1) begin : g_param_check
    $error("i2c_bus_arbiter: unsupported parameter values");
  end

  t_i2c_arb_state state, state_next;
  logic [1:0]     grant;
  logic           last_served;
  t_i2c_burst     beat_cnt;
  logic           we_q;
  logic           g;
  logic           prefer;
  logic [1:0]     pick;
  logic           cmd_fire, wr_fire, rd_fire, beat_fire, rd_owned;
  logic           wd_expire;

  assign g       = grant[1];
  assign o_grant = grant;
  assign prefer  = ~last_served;
  assign pick    = i_req_cmd_valid[prefer] ? (2'b01 << prefer) : (2'b01 << ~prefer);

  assign rd_owned  = (state == DATA) && !we_q;
  assign cmd_fire  = o_m_cmd_valid && i_m_cmd_ready;
  assign wr_fire   = o_m_wr_valid && i_m_wr_ready;
  assign rd_fire   = rd_owned && i_m_rd_valid && i_req_rd_ready[g];
  assign beat_fire = we_q ? wr_fire : rd_fire;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_served <= 1'b1;
      beat_cnt    <= '0;
      we_q        <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE:  if (|i_req_cmd_valid) grant <= pick;
        CMD: begin
          if (cmd_fire) begin
            we_q     <= i_req_cmd_data[g].we;
            beat_cnt <= (wr_fire && i_req_cmd_data[g].burst_num != '0)
                        ? i_req_cmd_data[g].burst_num - t_i2c_burst'(1)
                        : i_req_cmd_data[g].burst_num;
          end
        end
        DATA:  if (beat_fire && beat_cnt != '0) beat_cnt <= beat_cnt - t_i2c_burst'(1);
        DRAIN: begin
          if (!i_m_busy) begin
            grant       <= '0;
            last_served <= g;
          end
        end
        default: ;
      endcase
      if (wd_expire) begin
        grant       <= '0;
        last_served <= g;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (|i_req_cmd_valid) state_next = CMD;
      CMD: begin
        if (cmd_fire) begin
          state_next = (wr_fire && i_req_cmd_data[g].burst_num == '0) ? DRAIN : DATA;
        end
      end
      DATA:  if (beat_fire && beat_cnt == '0) state_next = DRAIN;
      DRAIN: if (!i_m_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (wd_expire) state_next = IDLE;
  end

  // In CMD the write beat is only offered together with an accepted command,
  // so the master can never take a data byte ahead of its command.
  always_comb begin
    o_req_cmd_ready = '0;
    o_req_wr_ready  = '0;
    o_req_rd_valid  = '0;
    o_m_cmd_valid   = 1'b0;
    o_m_wr_valid    = 1'b0;
    o_m_cmd_data    = i_req_cmd_data[g];
    o_m_wr_data     = i_req_wr_data[g];
    o_req_rd_data   = i_m_rd_data;
    o_m_rd_ready    = rd_owned ? i_req_rd_ready[g] : i_m_rd_valid;
    o_drop          = i_m_rd_valid && !rd_owned;
    case (state)
      CMD: begin
        o_m_cmd_valid      = i_req_cmd_valid[g];
        o_req_cmd_ready[g] = i_m_cmd_ready;
        if (i_req_cmd_data[g].we && i_req_cmd_valid[g] && i_m_cmd_ready) begin
          o_m_wr_valid      = i_req_wr_valid[g];
          o_req_wr_ready[g] = i_m_wr_ready;
        end
      end
      DATA: begin
        if (we_q) begin
          o_m_wr_valid      = i_req_wr_valid[g];
          o_req_wr_ready[g] = i_m_wr_ready;
        end else begin
          o_req_rd_valid[g] = i_m_rd_valid;
        end
      end
      default: ;
    endcase
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int c_wd_w = $clog2(p_timeout_cycles + 1);
  logic [c_wd_w-1:0] wd_cnt;

  // Counts cycles spent in the current busy state; any state change restarts it.
  always_ff @(posedge i_clk) begin
    if (i_rst || state == IDLE || state_next != state) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + c_wd_w'(1);
    end
  end

  assign wd_expire = (state != IDLE) && (wd_cnt == c_wd_w'(p_timeout_cycles - 1));
`else
  assign wd_expire = 1'b0;
`endif

  assign o_timeout = wd_expire;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed self-checking bench for i2c_bus_arbiter; the bench itself plays the
// I2C master. Define I2C_ARB_TIMEOUT_EN to include the watchdog scenario.
module tb_i2c_bus_arbiter;
  import i2c_bus_arbiter_pkg::*;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int c_timeout = 100;
`else
  localparam int c_timeout = 2_500_000;
`endif

  logic       i_clk, i_rst;
  logic [1:0] req_cmd_valid, req_cmd_ready, req_wr_valid, req_wr_ready;
  logic [1:0] req_rd_valid, req_rd_ready, grant;
  t_i2c_cmd   req_cmd_data [2];
  logic [7:0] req_wr_data [2];
  logic [7:0] req_rd_data;
  logic       m_cmd_valid, m_cmd_ready, m_wr_valid, m_wr_ready;
  logic       m_rd_valid, m_rd_ready, m_busy, drop, timeout;
  t_i2c_cmd   m_cmd_data;
  logic [7:0] m_wr_data, m_rd_data;

  int total = 0;
  int bad = 0;
  int wr_beats = 0, rd1_n = 0, rd0_seen = 0, drop_n = 0, to_n = 0;
  int gl_n = 0, nonowner_bad = 0;
  logic [7:0] last_wr;
  logic [7:0] rd1_log [8];
  logic [1:0] grant_log [16];

  i2c_bus_arbiter #(.p_num_req(2), .p_timeout_cycles(c_timeout)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_cmd_valid(req_cmd_valid), .i_req_cmd_data(req_cmd_data),
    .o_req_cmd_ready(req_cmd_ready),
    .i_req_wr_valid(req_wr_valid), .i_req_wr_data(req_wr_data),
    .o_req_wr_ready(req_wr_ready),
    .o_req_rd_valid(req_rd_valid), .o_req_rd_data(req_rd_data),
    .i_req_rd_ready(req_rd_ready),
    .o_m_cmd_valid(m_cmd_valid), .o_m_cmd_data(m_cmd_data), .i_m_cmd_ready(m_cmd_ready),
    .o_m_wr_valid(m_wr_valid), .o_m_wr_data(m_wr_data), .i_m_wr_ready(m_wr_ready),
    .i_m_rd_valid(m_rd_valid), .i_m_rd_data(m_rd_data), .o_m_rd_ready(m_rd_ready),
    .i_m_busy(m_busy), .o_grant(grant), .o_drop(drop), .o_timeout(timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Handshakes that will complete on the coming rising edge, logged mid-cycle.
  always @(negedge i_clk) begin
    #2;
    if (!i_rst) begin
      if (m_wr_valid && m_wr_ready) begin
        wr_beats++;
        last_wr = m_wr_data;
      end
      if (req_rd_valid[1] && req_rd_ready[1] && rd1_n < 8) begin
        rd1_log[rd1_n] = req_rd_data;
        rd1_n++;
      end
      if (req_rd_valid[0]) rd0_seen++;
      if (drop) drop_n++;
      if (timeout) to_n++;
      if (m_cmd_valid && m_cmd_ready && gl_n < 16) begin
        grant_log[gl_n] = grant;
        gl_n++;
      end
      if (((req_cmd_ready | req_wr_ready) & ~grant) != 2'b00) nonowner_bad++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input t_i2c_cmd c, input logic [7:0] wd);
    req_cmd_valid[r] = 1'b1;
    req_cmd_data[r]  = c;
    req_wr_valid[r]  = c.we;
    req_wr_data[r]   = wd;
  endtask

  task automatic nextCycle();
    @(negedge i_clk);
  endtask

  t_i2c_cmd t0, t1;
  int       hit;

  initial begin
    i_rst = 1'b1;
    req_cmd_valid = '0; req_wr_valid = '0; req_rd_ready = '0;
    req_cmd_data[0] = '0; req_cmd_data[1] = '0;
    req_wr_data[0] = '0; req_wr_data[1] = '0;
    m_cmd_ready = 1'b0; m_wr_ready = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0; m_busy = 1'b0;
    repeat (2) nextCycle();
    #1;
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_req_outs", 32'({req_cmd_ready, req_wr_ready, req_rd_valid}), 32'd0);
    checkOutput("rst_m_outs", 32'({m_cmd_valid, m_wr_valid, m_rd_ready}), 32'd0);
    checkOutput("rst_pulses", 32'({drop, timeout}), 32'd0);
    i_rst = 1'b0;

    // Single write from requester 0
    nextCycle();
    t0 = '{1'b1, 7'h21, 8'h1E, 8'd0};
    applyStimulus(0, t0, 8'hA5);
    m_cmd_ready = 1'b1; m_wr_ready = 1'b1;
    #1 checkOutput("idle_no_grant", 32'({grant, m_cmd_valid}), 32'd0);
    nextCycle(); #1;
    checkOutput("wr_grant", 32'(grant), 32'b01);
    checkOutput("wr_cmd_data", 32'(m_cmd_data), 32'(t0));
    checkOutput("wr_fwd", 32'({m_cmd_valid, m_wr_valid, m_wr_data}), 32'h3A5);
    checkOutput("wr_readys", 32'({req_cmd_ready, req_wr_ready}), 32'b0101);
    m_busy = 1'b1;
    nextCycle();
    req_cmd_valid = '0; req_wr_valid = '0;
    #1 checkOutput("drain_hold", 32'({grant, m_wr_valid}), 32'b010);
    nextCycle();
    m_busy = 1'b0;
    nextCycle(); #1;
    checkOutput("wr_release", 32'(grant), 32'd0);
    checkOutput("wr_beats", 32'(wr_beats), 32'd1);
    checkOutput("wr_byte", 32'(last_wr), 32'hA5);

    // Burst read by requester 1 with a 5-cycle stall on the second byte
    t1 = '{1'b0, 7'h33, 8'h00, 8'd3};
    applyStimulus(1, t1, 8'h00);
    req_rd_ready = 2'b10;
    nextCycle(); #1;
    checkOutput("rd_grant", 32'({grant, m_cmd_valid, req_cmd_ready}), 32'b10_1_10);
    m_busy = 1'b1;
    nextCycle();
    req_cmd_valid = '0;
    for (int b = 0; b < 4; b++) begin
      m_rd_valid = 1'b1;
      m_rd_data  = 8'h10 + 8'(b);
      if (b == 1) begin
        req_rd_ready[1] = 1'b0;
        repeat (5) nextCycle();
        #1 checkOutput("rd_stall_hold", 32'({req_rd_valid, m_rd_ready, req_rd_data}), 32'h411);
        req_rd_ready[1] = 1'b1;
      end
      nextCycle();
    end
    m_rd_valid = 1'b0; m_busy = 1'b0;
    nextCycle(); #1;
    checkOutput("rd_release", 32'(grant), 32'd0);
    checkOutput("rd_beats", 32'(rd1_n), 32'd4);
    for (int k = 0; k < 4; k++) checkOutput("rd_byte", 32'(rd1_log[k]), 32'h10 + 32'(k));
    checkOutput("rd_other_quiet", 32'(rd0_seen), 32'd0);

    // Stray read byte while idle
    nextCycle();
    m_rd_valid = 1'b1; m_rd_data = 8'hEE;
    #1;
    checkOutput("drop_pulse", 32'({drop, m_rd_ready}), 32'b11);
    checkOutput("drop_no_owner", 32'(req_rd_valid), 32'd0);
    nextCycle();
    m_rd_valid = 1'b0;
    #1;
    checkOutput("drop_end", 32'(drop), 32'd0);
    checkOutput("drop_count", 32'(drop_n), 32'd1);

    // Contention: both requesters hold valid for four transactions
    begin
      int gl_start, wr_start;
      gl_start = gl_n; wr_start = wr_beats;
      t0 = '{1'b1, 7'h21, 8'h10, 8'd0};
      t1 = '{1'b1, 7'h22, 8'h20, 8'd0};
      applyStimulus(0, t0, 8'h40);
      applyStimulus(1, t1, 8'h41);
      repeat (12) nextCycle();
      req_cmd_valid = '0; req_wr_valid = '0;
      #1;
      checkOutput("rr_count", 32'(gl_n - gl_start), 32'd4);
      for (int k = 0; k < 4; k++)
        checkOutput("rr_order", 32'(grant_log[gl_start + k]), (k % 2 == 0) ? 32'b01 : 32'b10);
      checkOutput("rr_wr_beats", 32'(wr_beats - wr_start), 32'd4);
      checkOutput("nonowner_quiet", 32'(nonowner_bad), 32'd0);
    end

    // Reset in the middle of a write burst
    t0 = '{1'b1, 7'h21, 8'h30, 8'd2};
    applyStimulus(0, t0, 8'h55);
    m_wr_ready = 1'b0;
    nextCycle();
    nextCycle(); #1;
    checkOutput("mid_data", 32'({grant, m_wr_valid}), 32'b011);
    i_rst = 1'b1;
    nextCycle(); #1;
    checkOutput("mid_rst_outs",
                32'({grant, req_cmd_ready, req_wr_ready, m_cmd_valid, m_wr_valid}), 32'd0);
    i_rst = 1'b0;
    nextCycle(); #1;
    checkOutput("post_rst_grant", 32'(grant), 32'b01);
    req_cmd_valid = '0; req_wr_valid = '0;
    i_rst = 1'b1;
    nextCycle();
    i_rst = 1'b0;

`ifdef I2C_ARB_TIMEOUT_EN
    // Hung master: watchdog must release requester 0 and serve requester 1
    t0 = '{1'b1, 7'h21, 8'h40, 8'd0};
    t1 = '{1'b1, 7'h22, 8'h41, 8'd0};
    applyStimulus(0, t0, 8'h66);
    applyStimulus(1, t1, 8'h77);
    m_wr_ready = 1'b1; m_cmd_ready = 1'b1; m_busy = 1'b1;
    nextCycle(); #1;
    checkOutput("wd_first_grant", 32'(grant), 32'b01);
    nextCycle();
    req_cmd_valid[0] = 1'b0; req_wr_valid[0] = 1'b0;
    hit = 0;
    for (int i = 1; i <= 200 && hit == 0; i++) begin
      #1;
      if (timeout) hit = i;
      else nextCycle();
    end
    checkOutput("wd_cycles", 32'(hit), 32'd100);
    nextCycle(); #1;
    checkOutput("wd_released", 32'(grant), 32'd0);
    nextCycle(); #1;
    checkOutput("wd_next_grant", 32'(grant), 32'b10);
    checkOutput("wd_pulses", 32'(to_n), 32'd1);
    req_cmd_valid = '0; req_wr_valid = '0; m_busy = 1'b0;
`else
    checkOutput("no_wd_pulses", 32'(to_n), 32'd0);
`endif

    nextCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
